// File: rtl/mst_slv_link.sv
// mst_slv_link: master/slave loopback over a valid/ready bus.
// The master writes DEPTH words (base+idx) into the slave register file,
// reads them back one at a time and counts readback mismatches.
module mst_slv_link #(
    parameter int DW    = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] base,
    input  logic          slv_stall,
    input  logic          inj_err,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic          req_valid,
    output logic          req_ready,
    output logic          req_we,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] base_q;
    logic [DW-1:0] mem [DEPTH];

    logic          xfer;
    logic          last_idx;
    logic [AW-1:0] idx_inc;
    logic          rd_mismatch;
    logic [AW:0]   err_nxt;

    assign req_ready   = ~slv_stall;
    assign xfer        = req_valid & req_ready;
    assign last_idx    = (idx == AW'(DEPTH - 1));
    assign idx_inc     = idx + AW'(1);
    assign rd_mismatch = (rsp_rdata != (base_q + DW'(idx)));
    // Saturating increment; the count never wraps back to a "passing" value.
    assign err_nxt     = (rd_mismatch && !(&err_cnt)) ? err_cnt + (AW+1)'(1) : err_cnt;

    // Slave register file: written on a write transfer, never reset.
    always_ff @(posedge clk) begin
        if (xfer && req_we) begin
            mem[req_addr] <= req_wdata;
        end
    end

    // Slave read port: one-cycle response to each read transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= xfer & ~req_we;
            if (xfer && !req_we) begin
                rsp_rdata <= mem[req_addr] ^ {{(DW-1){1'b0}}, inj_err};
            end
        end
    end

    // Master FSM; all outputs registered and updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            base_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_WRITE;
                        base_q    <= base;
                        idx       <= '0;
                        err_cnt   <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        req_valid <= 1'b1;
                        req_we    <= 1'b1;
                        req_addr  <= '0;
                        req_wdata <= base;
                    end
                end
                S_WRITE: begin
                    if (xfer) begin
                        if (last_idx) begin
                            state    <= S_READ_REQ;
                            idx      <= '0;
                            req_we   <= 1'b0;
                            req_addr <= '0;
                        end else begin
                            idx       <= idx_inc;
                            req_addr  <= idx_inc;
                            req_wdata <= base_q + DW'(idx_inc);
                        end
                    end
                end
                S_READ_REQ: begin
                    if (xfer) begin
                        state     <= S_READ_WAIT;
                        req_valid <= 1'b0;
                    end
                end
                S_READ_WAIT: begin
                    if (rsp_valid) begin
                        err_cnt <= err_nxt;
                        if (last_idx) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            state     <= S_READ_REQ;
                            idx       <= idx_inc;
                            req_addr  <= idx_inc;
                            req_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mst_slv_link.sv
// Directed bench for mst_slv_link: loopback runs with stalls, injected
// read errors, mid-run reset and ignored restarts.
module tb_mst_slv_link;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] base = '0;
    logic          slv_stall = 1'b0;
    logic          inj_err = 1'b0;
    logic          busy, done, pass;
    logic [AW:0]   err_cnt;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] wr_data [DEPTH];
    int            wr_count = 0;

    mst_slv_link #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base),
        .slv_stall(slv_stall), .inj_err(inj_err),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    // Record every write transfer seen on the bus.
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready && req_we) begin
            wr_data[req_addr] = req_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic clear_log();
        for (int i = 0; i < DEPTH; i++) wr_data[i] = '1;
        wr_count = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One run. Cycle n is the period ending at edge n, edge 0 samples start.
    // Inputs set for cycle n are applied right after edge n-1.
    task automatic run(input logic [DW-1:0] base_v,
                       input int stall_from, input int stall_len,
                       input int inj_from, input int inj_to,
                       input int rs_from, input int rs_to,
                       output int done_cyc, output int done_num);
        int cyc;
        logic          pend;
        logic          p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        done_cyc = 0;
        done_num = 0;
        @(negedge clk);
        base  = base_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base  = ~base_v;
        cyc   = 1;
        pend  = 1'b0;
        p_we = 1'b0; p_addr = '0; p_wdata = '0;
        while (cyc < 75) begin
            if (pend && req_valid) begin
                checks++;
                if (req_we !== p_we || req_addr !== p_addr || req_wdata !== p_wdata) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got we=%b addr=%0d wdata=%h want we=%b addr=%0d wdata=%h",
                             cyc, req_we, req_addr, req_wdata, p_we, p_addr, p_wdata);
                end
            end
            if (done) begin
                done_num++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            slv_stall = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            inj_err   = (cyc >= inj_from) && (cyc < inj_to);
            start     = (cyc >= rs_from) && (cyc < rs_to);
            pend    = req_valid && slv_stall;
            p_we    = req_we;
            p_addr  = req_addr;
            p_wdata = req_wdata;
            @(posedge clk);
            #1;
            cyc++;
        end
        slv_stall = 1'b0;
        inj_err   = 1'b0;
        start     = 1'b0;
    endtask

    task automatic check_result(input string name, input int done_cyc, input int exp_cyc,
                                input int done_num, input logic exp_pass,
                                input logic [AW:0] exp_err);
        checks++;
        if (done_cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s_done_cycle got %0d want %0d", name, done_cyc, exp_cyc);
        end
        checks++;
        if (done_num !== 1) begin
            errors++;
            $display("FAIL %s_done_pulses got %0d want 1", name, done_num);
        end
        checks++;
        if (pass !== exp_pass) begin
            errors++;
            $display("FAIL %s_pass got %b want %b", name, pass, exp_pass);
        end
        checks++;
        if (err_cnt !== exp_err) begin
            errors++;
            $display("FAIL %s_err_cnt got %0d want %0d", name, err_cnt, exp_err);
        end
    endtask

    task automatic check_writes(input string name, input logic [DW-1:0] base_v);
        logic [DW-1:0] exp;
        checks++;
        if (wr_count !== DEPTH) begin
            errors++;
            $display("FAIL %s_write_count got %0d want %0d", name, wr_count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = base_v + DW'(i);
            checks++;
            if (wr_data[i] !== exp) begin
                errors++;
                $display("FAIL %s_wdata[%0d] got %h want %h", name, i, wr_data[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, pass, req_valid, rsp_valid} !== 5'b0 || err_cnt !== '0 ||
            req_addr !== '0 || req_wdata !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b pass=%b rv=%b rspv=%b err=%0d addr=%0d wd=%h rd=%h want all 0",
                     busy, done, pass, req_valid, rsp_valid, err_cnt, req_addr, req_wdata, rsp_rdata);
        end
    endtask

    task automatic test_basic();
        int dc, dn;
        clear_log();
        run(64'h1000, 0, 0, 0, 0, 0, 0, dc, dn);
        check_result("basic", dc, 49, dn, 1'b1, 5'd0);
        check_writes("basic", 64'h1000);
    endtask

    task automatic test_stall();
        int dc, dn;
        clear_log();
        run(64'h2000, 5, 5, 0, 0, 0, 0, dc, dn);
        check_result("stall", dc, 54, dn, 1'b1, 5'd0);
        check_writes("stall", 64'h2000);
    endtask

    task automatic test_inj_all();
        int dc, dn;
        run(64'h3000, 0, 0, 17, 49, 0, 0, dc, dn);
        check_result("inj_all", dc, 49, dn, 1'b0, 5'd16);
    endtask

    task automatic test_inj_one();
        int dc, dn;
        run(64'h4000, 0, 0, 23, 24, 0, 0, dc, dn);
        check_result("inj_one", dc, 49, dn, 1'b0, 5'd1);
    endtask

    task automatic test_reset_mid();
        int dc, dn;
        @(negedge clk);
        base  = 64'h5000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || req_valid !== 1'b0 || err_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b req_valid=%b err=%0d done=%b want 0 0 0 0",
                     busy, req_valid, err_cnt, done);
        end
        rst = 1'b0;
        clear_log();
        run(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 0, 0, dc, dn);
        check_result("wrap", dc, 49, dn, 1'b1, 5'd0);
        check_writes("wrap", 64'hFFFF_FFFF_FFFF_FFF8);
        checks++;
        if (wr_data[8] !== 64'd0 || wr_data[15] !== 64'd7) begin
            errors++;
            $display("FAIL wrap_values got [8]=%h [15]=%h want 0 7", wr_data[8], wr_data[15]);
        end
    endtask

    task automatic test_start_busy();
        int dc, dn;
        clear_log();
        run(64'h6000, 0, 0, 0, 0, 10, 30, dc, dn);
        check_result("start_busy", dc, 49, dn, 1'b1, 5'd0);
        check_writes("start_busy", 64'h6000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_inj_all();
        test_inj_one();
        test_reset_mid();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
